// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised decode-stage register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_SWEEP
    } rf_state_t;

    // Address width needed to index n registers (minimum 1 bit).
    function automatic int addr_w_of(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Background clear sequencer: walks every register once, issuing zero writes.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RF_IDLE  | waiting for clr_start; no sweep writes
//   RF_SWEEP | writing zero to register ptr each cycle, ptr 0..NUM_REGS-1
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_next;

    // State, pointer and registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RF_IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            clr_busy <= (state_next == RF_SWEEP);
        end
    end

    // Next-state: start on clr_start, stop after the last register; no restart mid-sweep.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            RF_IDLE: begin
                if (clr_start) begin
                    state_next = RF_SWEEP;
                    ptr_next   = '0;
                end
            end
            RF_SWEEP: begin
                if (ptr == LAST_PTR) begin
                    state_next = RF_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_next = RF_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    assign sweep_we   = (state == RF_SWEEP);
    assign sweep_addr = ptr;

endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with write-through bypass, pending scoreboard
// and a background clear sweep.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 24,
    parameter  int NUM_REGS = 16,
    parameter  int NUM_RD   = 3,
    parameter  int ZERO_R0  = 0,
    localparam int ADDR_W   = addr_w_of(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_vld,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic [NUM_REGS-1:0]      pend_vec
);

    localparam logic [ADDR_W:0] NREGS_X = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend_next;
    logic                sweep_we;
    logic [ADDR_W-1:0]   sweep_addr;
    logic                port_we;
    logic                issue_ok;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Address refers to a real, writable/readable register (R0 excluded when hardwired).
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_X) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    regfile_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .reset      (reset),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    assign port_we   = we && !clr_busy && addr_live(wr_addr);
    assign issue_ok  = issue_vld && !clr_busy && addr_live(issue_addr);
    assign mem_we    = sweep_we || port_we;
    assign mem_waddr = sweep_we ? sweep_addr : wr_addr;
    assign mem_wdata = sweep_we ? '0 : wr_data;

    // Storage array: single write port shared by the sweep and the external port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (mem_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (mem_waddr == ADDR_W'(i)) regs[i] <= mem_wdata;
            end
        end
    end

    // Scoreboard next state: a write retires the producer, an issue (newer) wins.
    always_comb begin
        pend_next = pend_vec;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (mem_we && (mem_waddr == ADDR_W'(i))) pend_next[i] = 1'b0;
            if (issue_ok && (issue_addr == ADDR_W'(i))) pend_next[i] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend_vec <= '0;
        else        pend_vec <= pend_next;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] dat_next;
        logic              pnd_next;
        logic [DATA_W-1:0] dat_q;
        logic              pnd_q;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux with bypass of the write landing this cycle.
        always_comb begin
            dat_next = '0;
            pnd_next = 1'b0;
            if (addr_live(ra)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (ra == ADDR_W'(i)) begin
                        dat_next = regs[i];
                        pnd_next = pend_next[i];
                    end
                end
                if (mem_we && (mem_waddr == ra)) dat_next = mem_wdata;
            end
        end

        // Registered read outputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dat_q <= '0;
                pnd_q <= 1'b0;
            end else begin
                dat_q <= dat_next;
                pnd_q <= pnd_next;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = dat_q;
        assign rd_pending[k]               = pnd_q;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: two DUT configurations share stimulus; a reference model
// pushes expected outputs per cycle and a monitor pops and compares them.
module tb_regfile_param;

    localparam int DW = 24;
    localparam int NR = 3;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] rd_addr;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             issue_vld;
    logic [AW-1:0]    issue_addr;
    logic             clr_start;

    logic [NR*DW-1:0] rd_data0, rd_data1;
    logic [NR-1:0]    rdp0, rdp1;
    logic             busy0, busy1;
    logic [15:0]      pv0;
    logic [11:0]      pv1;

    regfile_param #(.DATA_W(DW), .NUM_REGS(16), .NUM_RD(NR), .ZERO_R0(0)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_pending(rdp0),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_vld(issue_vld),
        .issue_addr(issue_addr), .clr_start(clr_start), .clr_busy(busy0), .pend_vec(pv0)
    );

    regfile_param #(.DATA_W(DW), .NUM_REGS(12), .NUM_RD(NR), .ZERO_R0(1)) dut_z (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_pending(rdp1),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_vld(issue_vld),
        .issue_addr(issue_addr), .clr_start(clr_start), .clr_busy(busy1), .pend_vec(pv1)
    );

    typedef struct {
        logic [NR*DW-1:0] d0, d1;
        logic [NR-1:0]    p0, p1;
        logic             b0, b1;
        logic [15:0]      pv0;
        logic [11:0]      pv1;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: contents, pending bits and remaining sweep cycles per configuration.
    logic [DW-1:0] m_mem [2][16];
    bit            m_pend[2][16];
    int            m_left[2];
    int            m_idx [2];
    int            m_n   [2] = '{16, 12};
    bit            m_z   [2] = '{1'b0, 1'b1};

    function automatic void model_reset();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[j][i]  = '0;
                m_pend[j][i] = 1'b0;
            end
            m_left[j] = 0;
            m_idx[j]  = 0;
        end
    endfunction

    function automatic void model_step();
        exp_t          e;
        bit            busy, wv, iv, ok;
        int            wa, ia, ra;
        logic [DW-1:0] wd;
        logic [NR*DW-1:0] dd;
        logic [NR-1:0] pp;
        logic [15:0]   pv;
        for (int j = 0; j < 2; j++) begin
            busy = (m_left[j] > 0);
            ia   = int'(issue_addr);
            if (busy) begin
                wv = 1'b1; wa = m_idx[j]; wd = '0;
            end else begin
                wa = int'(wr_addr); wd = wr_data;
                wv = we && (wa < m_n[j]) && !(m_z[j] && wa == 0);
            end
            iv = issue_vld && !busy && (ia < m_n[j]) && !(m_z[j] && ia == 0);
            for (int k = 0; k < NR; k++) begin
                ra = int'(rd_addr[k*AW +: AW]);
                ok = (ra < m_n[j]) && !(m_z[j] && ra == 0);
                if (!ok)                  dd[k*DW +: DW] = '0;
                else if (wv && wa == ra)  dd[k*DW +: DW] = wd;
                else                      dd[k*DW +: DW] = m_mem[j][ra];
            end
            if (wv) begin
                m_mem[j][wa]  = wd;
                m_pend[j][wa] = 1'b0;
            end
            if (iv) m_pend[j][ia] = 1'b1;
            for (int k = 0; k < NR; k++) begin
                ra = int'(rd_addr[k*AW +: AW]);
                ok = (ra < m_n[j]) && !(m_z[j] && ra == 0);
                pp[k] = ok ? m_pend[j][ra] : 1'b0;
            end
            if (busy) begin
                m_idx[j]++;
                m_left[j]--;
            end else if (clr_start) begin
                m_left[j] = m_n[j];
                m_idx[j]  = 0;
            end
            pv = '0;
            for (int i = 0; i < m_n[j]; i++) pv[i] = m_pend[j][i];
            if (j == 0) begin
                e.d0 = dd; e.p0 = pp; e.b0 = (m_left[j] > 0); e.pv0 = pv;
            end else begin
                e.d1 = dd; e.p1 = pp; e.b1 = (m_left[j] > 0); e.pv1 = pv[11:0];
            end
        end
        q.push_back(e);
    endfunction

    // Monitor: outputs are presented every cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data_a",    rd_data0, e.d0);
                chk("rd_pending_a", rdp0,     e.p0);
                chk("clr_busy_a",   busy0,    e.b0);
                chk("pend_vec_a",   pv0,      e.pv0);
                chk("rd_data_z",    rd_data1, e.d1);
                chk("rd_pending_z", rdp1,     e.p1);
                chk("clr_busy_z",   busy1,    e.b1);
                chk("pend_vec_z",   pv1,      e.pv1);
            end
        end
    end

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        we = 1'b0; issue_vld = 1'b0; clr_start = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_data_a"},  rd_data0, '0);
        chk({tag, "_rd_pend_a"},  rdp0,     '0);
        chk({tag, "_busy_a"},     busy0,    '0);
        chk({tag, "_pend_vec_a"}, pv0,      '0);
        chk({tag, "_rd_data_z"},  rd_data1, '0);
        chk({tag, "_busy_z"},     busy1,    '0);
        chk({tag, "_pend_vec_z"}, pv1,      '0);
    endtask

    task automatic read_all();
        idle_in();
        for (int i = 0; i < 16; i++) begin
            set_rd(i, 15 - i, (i + 7) % 16);
            step();
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; wr_addr = AW'(i); wr_data = DW'(i + 1);
            set_rd(i, (i + 15) % 16, 13);
            step();
        end
        we = 1'b0;
    endtask

    initial begin
        idle_in();
        rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
        model_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        // Reset contents of every register.
        read_all();

        // Same-cycle write and read: bypass.
        we = 1'b1; wr_addr = 4'd5; wr_data = 24'hABCDEF; set_rd(5, 0, 5);
        step();
        idle_in(); step();

        // Scoreboard: issue, then write+issue (set wins), then write alone.
        issue_vld = 1'b1; issue_addr = 4'd3; set_rd(3, 5, 3);
        step();
        idle_in(); step();
        we = 1'b1; wr_addr = 4'd3; wr_data = 24'h000011; issue_vld = 1'b1; issue_addr = 4'd3;
        step();
        idle_in(); we = 1'b1; wr_addr = 4'd3; wr_data = 24'h000011;
        step();
        idle_in(); step();

        // R0 write/issue, and out-of-range address 13 for the 12-entry file.
        we = 1'b1; wr_addr = 4'd0; wr_data = 24'hFFFFFF; set_rd(0, 0, 0);
        step();
        idle_in(); step();
        issue_vld = 1'b1; issue_addr = 4'd0;
        step();
        idle_in(); step();
        we = 1'b1; wr_addr = 4'd13; wr_data = 24'h123456; issue_vld = 1'b1; issue_addr = 4'd13;
        set_rd(13, 13, 12);
        step();
        idle_in(); step();

        // Fill, sweep with writes/issues/second clr_start during it, then read back.
        fill();
        clr_start = 1'b1; set_rd(1, 2, 3);
        step();
        for (int c = 0; c < 18; c++) begin
            clr_start  = (c == 5);
            we         = 1'b1;
            wr_addr    = AW'(c % 16);
            wr_data    = DW'($urandom);
            issue_vld  = 1'b1;
            issue_addr = AW'($urandom_range(0, 15));
            rd_addr    = (NR*AW)'($urandom);
            step();
        end
        read_all();

        // Reset asserted mid-sweep.
        fill();
        issue_vld = 1'b1; issue_addr = 4'd9;
        step();
        idle_in(); clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (7) step();
        #2 reset = 1'b0;
        #1 check_zero("rst_mid");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        read_all();

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            we         = 1'($urandom);
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
            issue_vld  = 1'($urandom);
            issue_addr = AW'($urandom);
            clr_start  = ($urandom_range(0, 39) == 0);
            rd_addr    = (NR*AW)'($urandom);
            step();
        end
        idle_in();
        read_all();

        repeat (2) @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
